// File: rtl/ena_trigger_mc.sv
// ena_trigger_mc: multi-channel enable-run trigger generator with an event counter.
//   clk      : single clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   ena      : per-channel enable, sampled each edge
//   thresh   : shared run length that fires a trigger (0 disables triggering)
//   mode     : 00 one-shot, 01 periodic, 10 level, 11 one-shot
//   evt_clr  : synchronous clear of evt_cnt (wins over events at the same edge)
//   trig     : per-channel registered trigger
//   trig_any : registered OR of trig, aligned with trig
//   evt_cnt  : saturating count of trigger events
module ena_trigger_mc #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned EVT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ena,
   input  logic [CNT_W-1:0]  thresh,
   input  logic [1:0]        mode,
   input  logic              evt_clr,
   output logic [NUM_CH-1:0] trig,
   output logic              trig_any,
   output logic [EVT_W-1:0]  evt_cnt
);

   // Sum width leaves room for a popcount of up to 16 channels on top of the counter.
   localparam int unsigned SUM_W = EVT_W + 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [EVT_W-1:0] EVT_MAX = '1;

   typedef enum logic [1:0] {
      MODE_ONESHOT  = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_LEVEL    = 2'b10,
      MODE_RSVD     = 2'b11
   } mode_e;

   logic [NUM_CH-1:0][CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0] nxt;
   logic [NUM_CH-1:0]            fired_q, fired_d;
   logic [NUM_CH-1:0]            trig_q, trig_d;
   logic [NUM_CH-1:0]            hit;
   logic [NUM_CH-1:0]            pulse;
   logic                         trig_any_q, trig_any_d;
   logic [EVT_W-1:0]             evt_cnt_q, evt_cnt_d;
   logic [SUM_W-1:0]             evt_num;
   logic [SUM_W-1:0]             evt_sum;
   logic                         thresh_nz;
   logic                         is_oneshot;

   // Per-channel run counting, trigger decision and event detection.
   always_comb begin
      run_cnt_d  = run_cnt_q;
      fired_d    = fired_q;
      trig_d     = '0;
      nxt        = '0;
      hit        = '0;
      pulse      = '0;
      evt_num    = '0;
      thresh_nz  = (thresh != '0);
      is_oneshot = (mode_e'(mode) == MODE_ONESHOT) || (mode_e'(mode) == MODE_RSVD);

      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ena[i]) begin
            nxt[i] = (run_cnt_q[i] == CNT_MAX) ? CNT_MAX : run_cnt_q[i] + CNT_W'(1);
         end
         hit[i]       = ena[i] && thresh_nz && (nxt[i] == thresh);
         run_cnt_d[i] = nxt[i];

         case (mode_e'(mode))
            MODE_PERIODIC: begin
               // Reload to 0 so the next pulse lands thresh edges later.
               trig_d[i] = hit[i];
               pulse[i]  = hit[i];
               if (hit[i]) begin
                  run_cnt_d[i] = '0;
               end
            end
            MODE_LEVEL: begin
               trig_d[i] = ena[i] && thresh_nz && (nxt[i] >= thresh);
            end
            default: begin
               // The fired flag blocks a repeat when the counter saturates at thresh.
               trig_d[i] = hit[i] && !fired_q[i];
            end
         endcase

         fired_d[i] = ena[i] && (fired_q[i] || (trig_d[i] && is_oneshot));

         // A periodic pulse always counts; otherwise only a rising trig counts.
         if (pulse[i] || (trig_d[i] && !trig_q[i])) begin
            evt_num = evt_num + SUM_W'(1);
         end
      end

      trig_any_d = |trig_d;

      evt_sum = SUM_W'(evt_cnt_q) + evt_num;
      if (evt_clr) begin
         evt_cnt_d = '0;
      end else if (evt_sum > SUM_W'(EVT_MAX)) begin
         evt_cnt_d = EVT_MAX;
      end else begin
         evt_cnt_d = EVT_W'(evt_sum);
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q  <= '0;
         fired_q    <= '0;
         trig_q     <= '0;
         trig_any_q <= 1'b0;
         evt_cnt_q  <= '0;
      end else begin
         run_cnt_q  <= run_cnt_d;
         fired_q    <= fired_d;
         trig_q     <= trig_d;
         trig_any_q <= trig_any_d;
         evt_cnt_q  <= evt_cnt_d;
      end
   end

   assign trig     = trig_q;
   assign trig_any = trig_any_q;
   assign evt_cnt  = evt_cnt_q;

endmodule

// File: tb/tb_ena_trigger_mc.sv
// Self-checking bench for ena_trigger_mc (NUM_CH=2, CNT_W=4, EVT_W=8):
// directed table, hand-written corner sequences and random stimulus against a reference model.
module tb_ena_trigger_mc;

   logic       clk;
   logic       rst;
   logic [1:0] ena;
   logic [3:0] thresh;
   logic [1:0] mode;
   logic       evt_clr;
   logic [1:0] trig;
   logic       trig_any;
   logic [7:0] evt_cnt;

   int n_vec;
   int n_bad;

   // Reference model state: run lengths as integers.
   int         m_run   [2];
   bit         m_fired [2];
   bit         m_prev  [2];
   int         m_evt;
   logic [1:0] m_trig;

   typedef struct {
      logic       r;
      logic [1:0] e;
      logic [3:0] th;
      logic [1:0] md;
      logic       c;
      logic [1:0] exp_trig;
      logic [7:0] exp_evt;
   } vec_t;

   vec_t tbl[$];

   ena_trigger_mc #(.NUM_CH(2), .CNT_W(4), .EVT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .thresh   (thresh),
      .mode     (mode),
      .evt_clr  (evt_clr),
      .trig     (trig),
      .trig_any (trig_any),
      .evt_cnt  (evt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic [1:0] e, input int th,
                               input int md, input logic c);
      int ev;
      int n;
      bit t;
      bit per;
      if (r) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_run[ch] = 0; m_fired[ch] = 0; m_prev[ch] = 0;
         end
         m_evt  = 0;
         m_trig = 2'b00;
      end else begin
         ev = 0;
         for (int ch = 0; ch < 2; ch++) begin
            t   = 0;
            per = 0;
            n   = e[ch] ? ((m_run[ch] + 1 > 15) ? 15 : m_run[ch] + 1) : 0;
            if (th != 0 && e[ch]) begin
               if (md == 1) begin
                  if (n == th) begin t = 1; per = 1; n = 0; end
               end else if (md == 2) begin
                  t = (n >= th);
               end else begin
                  t = (n == th) && !m_fired[ch];
               end
            end
            m_fired[ch] = e[ch] && (m_fired[ch] || (t && (md == 0 || md == 3)));
            if (per || (t && !m_prev[ch])) ev++;
            m_prev[ch] = t;
            m_run[ch]  = n;
            m_trig[ch] = t;
         end
         m_evt = c ? 0 : ((m_evt + ev > 255) ? 255 : m_evt + ev);
      end
   endtask

   // Apply one edge worth of inputs, then compare against the model.
   task automatic step(input logic r, input logic [1:0] e, input logic [3:0] th,
                       input logic [1:0] md, input logic c);
      rst = r; ena = e; thresh = th; mode = md; evt_clr = c;
      @(posedge clk);
      #1;
      model_update(r, e, int'(th), int'(md), c);
      check("model_trig", 32'(trig), 32'(m_trig));
      check("model_trig_any", 32'(trig_any), 32'(|m_trig));
      check("model_evt_cnt", 32'(evt_cnt), 32'(m_evt));
   endtask

   function automatic void add(input logic r, input logic [1:0] e, input logic [3:0] th,
                               input logic [1:0] md, input logic c,
                               input logic [1:0] et, input logic [7:0] ee);
      vec_t v;
      v.r = r; v.e = e; v.th = th; v.md = md; v.c = c; v.exp_trig = et; v.exp_evt = ee;
      tbl.push_back(v);
   endfunction

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1; ena = '0; thresh = '0; mode = '0; evt_clr = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         m_run[ch] = 0; m_fired[ch] = 0; m_prev[ch] = 0;
      end
      m_evt  = 0;
      m_trig = '0;

      // Directed table: reset, periodic thr=3, level thr=4, clear colliding with a pulse.
      add(1, 2'b11, 4'd3, 2'd1, 0, 2'b00, 8'd0);
      add(1, 2'b00, 4'd3, 2'd1, 0, 2'b00, 8'd0);
      for (int k = 1; k <= 10; k++) begin
         add(0, 2'b10, 4'd3, 2'd1, 0, (k % 3 == 0) ? 2'b10 : 2'b00, 8'(k / 3));
      end
      add(0, 2'b00, 4'd3, 2'd1, 0, 2'b00, 8'd3);
      for (int k = 1; k <= 7; k++) begin
         add(0, 2'b01, 4'd4, 2'd2, 0, (k >= 4) ? 2'b01 : 2'b00, (k >= 4) ? 8'd4 : 8'd3);
      end
      add(0, 2'b00, 4'd4, 2'd2, 0, 2'b00, 8'd4);
      add(0, 2'b01, 4'd2, 2'd0, 0, 2'b00, 8'd4);
      add(0, 2'b01, 4'd2, 2'd0, 1, 2'b01, 8'd0);
      add(0, 2'b00, 4'd2, 2'd0, 0, 2'b00, 8'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].th, tbl[i].md, tbl[i].c);
         check("tbl_trig", 32'(trig), 32'(tbl[i].exp_trig));
         check("tbl_trig_any", 32'(trig_any), 32'(|tbl[i].exp_trig));
         check("tbl_evt_cnt", 32'(evt_cnt), 32'(tbl[i].exp_evt));
      end

      // One-shot thr=10: one pulse on a 10-run, none on shorter runs.
      step(1, 2'b00, 4'd10, 2'd0, 0);
      for (int k = 1; k <= 10; k++) begin
         step(0, 2'b01, 4'd10, 2'd0, 0);
         check("os_pulse", 32'(trig[0]), (k == 10) ? 32'd1 : 32'd0);
      end
      step(0, 2'b00, 4'd10, 2'd0, 0);
      check("os_after_low", 32'(trig[0]), 32'd0);
      check("os_evt_one", 32'(evt_cnt), 32'd1);
      for (int len = 9; len >= 1; len--) begin
         for (int k = 0; k < len; k++) begin
            step(0, 2'b01, 4'd10, 2'd0, 0);
            check("os_short_run", 32'(trig[0]), 32'd0);
         end
         step(0, 2'b00, 4'd10, 2'd0, 0);
      end
      check("os_evt_still_one", 32'(evt_cnt), 32'd1);

      // Periodic thr=1 on both channels: trig held high, two events per edge up to 254.
      step(1, 2'b00, 4'd1, 2'd1, 0);
      for (int k = 0; k < 127; k++) begin
         step(0, 2'b11, 4'd1, 2'd1, 0);
      end
      check("per1_held", 32'(trig), 32'd3);
      check("preload_254", 32'(evt_cnt), 32'd254);
      step(0, 2'b00, 4'd5, 2'd0, 0);
      for (int k = 1; k <= 5; k++) begin
         step(0, 2'b11, 4'd5, 2'd0, 0);
      end
      check("simul_trig", 32'(trig), 32'd3);
      check("evt_saturate", 32'(evt_cnt), 32'd255);
      step(0, 2'b00, 4'd5, 2'd0, 0);

      // Reset mid-run discards the partial run.
      step(1, 2'b00, 4'd10, 2'd0, 0);
      for (int k = 0; k < 6; k++) step(0, 2'b01, 4'd10, 2'd0, 0);
      step(1, 2'b01, 4'd10, 2'd0, 1);
      check("rst_trig", 32'(trig), 32'd0);
      check("rst_evt", 32'(evt_cnt), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step(0, 2'b01, 4'd10, 2'd0, 0);
         check("post_rst_pulse", 32'(trig[0]), (k == 10) ? 32'd1 : 32'd0);
      end

      // thresh=0: no triggers whatever ena does.
      for (int k = 0; k < 40; k++) begin
         step(0, 2'(k), 4'd0, 2'(k / 10), 0);
         check("thr0_trig", 32'(trig), 32'd0);
      end

      // Random stimulus against the model.
      begin
         logic [3:0] th;
         logic [1:0] md;
         logic [1:0] e;
         th = 4'd3;
         md = 2'd0;
         for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(39) == 0)
               th = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(5));
            if ($urandom_range(59) == 0) md = 2'($urandom_range(3));
            e[0] = ($urandom_range(9) < 8);
            e[1] = ($urandom_range(9) < 7);
            step($urandom_range(199) == 0, e, th, md, $urandom_range(49) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ena_trigger_mc.md
ENA_TRIGGER_MC -- requirements
Module: ena_trigger_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent enable/trigger channels (1..16).
REQ-002 Parameter CNT_W, default 4, width of per-channel run counter and threshold.
REQ-003 Parameter EVT_W, default 8, width of the trigger event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ena  input  NUM_CH  per-channel enable, sampled each rising edge.
REQ-007 thresh  input  CNT_W  run length that fires a trigger, shared by all channels.
REQ-008 mode  input  2  00 one-shot, 01 periodic, 10 level, 11 reserved (behaves as one-shot).
REQ-009 evt_clr  input  1  synchronous clear of evt_cnt.
REQ-010 trig  output  NUM_CH  per-channel registered trigger.
REQ-011 trig_any  output  1  registered OR of all bits of the next trig value, aligned with trig.
REQ-012 evt_cnt  output  EVT_W  saturating count of trigger events since reset or clear.

Function
REQ-013 Each channel SHALL keep run_cnt[i]: ena[i]=0 at an edge -> 0; ena[i]=1 -> run_cnt+1, saturating at 2^CNT_W-1.
REQ-014 "nxt" is the run_cnt value written at the current edge; all trigger decisions SHALL use nxt and the current thresh/mode.
REQ-015 One-shot: trig[i] high for exactly one cycle after the edge where nxt == thresh; no further pulse until ena[i] has been sampled low.
REQ-016 Periodic: as one-shot, but when nxt == thresh the run counter SHALL reload to 0 instead of thresh, so pulses repeat every thresh cycles while ena[i] stays high.
REQ-017 Level: trig[i] high after every edge where ena[i]=1 and nxt >= thresh; low after the first edge with ena[i]=0.
REQ-018 With thresh == 1, one-shot pulses on the first high edge; periodic pulses on every high edge, i.e. trig[i] held high.
REQ-019 With thresh == 0, trig, trig_any and event counting SHALL stay 0; run counters keep counting.
REQ-020 thresh changes take effect at the next edge; one-shot uses equality, so lowering thresh below a live run_cnt produces no pulse for that run.
REQ-021 Mode changes take effect at the next edge; run counters are not cleared by a mode change.
REQ-022 Trigger latency: first pulse is visible in the cycle after the thresh-th consecutive edge with ena[i] sampled high.
REQ-023 An event is a 0->1 transition of trig[i] or a periodic pulse; in level mode a held-high trig counts once.
REQ-024 Per edge, evt_cnt SHALL add the number of channels with an event (popcount, 0..NUM_CH), saturating at 2^EVT_W-1.
REQ-025 evt_clr has priority: evt_cnt becomes 0 and events at that same edge are discarded.
REQ-026 Channels SHALL be fully independent; simultaneous triggers on several channels are all reported and counted.

Reset
REQ-027 While rst=1 at an edge: all run_cnt = 0, trig = 0, trig_any = 0, evt_cnt = 0, and the one-shot fired flags are cleared; rst overrides ena and evt_clr.
REQ-028 Reset mid-run SHALL discard the partial run; counting restarts from 0 at the first edge after rst falls with ena high.
REQ-029 All outputs are registered; no output depends combinationally on inputs.

Verification (NUM_CH=2, CNT_W=4, EVT_W=8)
REQ-030 One-shot, thresh=10, ena[0] high 10 cycles then low -> trig[0] one pulse after the 10th edge; evt_cnt=1; runs of 9,8,...,1 cycles -> no pulse, evt_cnt stays 1.
REQ-031 Periodic, thresh=3, ena[1] high 10 cycles -> trig[1] pulses after edges 3, 6, 9; evt_cnt=3; trig_any mirrors them.
REQ-032 Level, thresh=4, ena[0] high 7 cycles -> trig[0] high for 4 cycles (edges 4..7), low after ena falls; evt_cnt increments by 1.
REQ-033 Both channels one-shot, thresh=5, identical ena -> simultaneous trig=2'b11, evt_cnt +2 in one cycle; evt_cnt preloaded to 254 -> saturates at 255.
REQ-034 rst=1 for one edge after 6 of 10 enable cycles -> all outputs 0; pulse after the 10th consecutive high edge following rst release.
REQ-035 evt_clr asserted on the same edge as a trigger -> evt_cnt=0 next cycle, trig still pulses; thresh=0 -> no trig for any ena pattern.
